// File: rtl/swap_pair_pkg.sv
// ---------------------------------------------------------------------------
// swap_pair_pkg
// Shared types for the swap-pair loader and the compare/swap helpers that
// later sorting-network stages reuse.
//   mode_e  : per-pair swap policy (pass, always swap, sort asc, sort desc)
//   state_e : loader pair-assembly state (empty, one word held, pair ready)
// ---------------------------------------------------------------------------
package swap_pair_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_SWAP = 2'b01,
      MODE_ASC  = 2'b10,
      MODE_DESC = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_HALF  = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

endpackage : swap_pair_pkg

// File: rtl/swap_decide.sv
// ---------------------------------------------------------------------------
// swap_decide
// Combinational swap decision for an ordered word pair (a first, b second).
// Ports:
//   mode : swap policy (mode_e)
//   a    : first word of the pair
//   b    : second word of the pair
//   swap : 1 when the pair should be exchanged; equal words never swap in
//          the sort modes, so sorting stays stable.
// ---------------------------------------------------------------------------
module swap_decide
   import swap_pair_pkg::*;
#(
   parameter int N = 8
) (
   input  mode_e        mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         swap
);

   always_comb begin
      // NOTE: default assignment first so no path leaves swap unassigned
      // (which would infer a latch).
      swap = 1'b0;
      unique case (mode)
         MODE_PASS: swap = 1'b0;
         MODE_SWAP: swap = 1'b1;
         MODE_ASC:  swap = (a > b);
         MODE_DESC: swap = (a < b);
         default:   swap = 1'b0;
      endcase
   end

endmodule : swap_decide

// File: rtl/swap_pair_loader.sv
// ---------------------------------------------------------------------------
// swap_pair_loader
// Upstream feeder for data_swapper: collects a valid/ready word stream into
// ordered pairs, decides per pair whether to swap, and presents registered
// in1/in2/swap_en behind a valid/ready handshake.
//
// Build option: define SWAP_PAIR_FLUSH_EN to let `flush` emit a held lone
// word padded with PAD (pair_pad=1). Without it, flush is ignored and
// pair_pad is tied low.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   cfg_mode      : swap policy, latched with the first word of each pair
//   s_valid/s_data/s_ready : input word stream
//   flush         : single-cycle request to emit a held lone word
//   pair_valid/pair_ready  : output pair handshake
//   pair_in1/pair_in2      : first/second word, to data_swapper in1/in2
//   pair_swap_en  : to data_swapper swap_en
//   pair_pad      : pair_in2 is filler, not real data
//   pair_cnt      : pairs handed off, wraps
// ---------------------------------------------------------------------------
module swap_pair_loader
   import swap_pair_pkg::*;
#(
   parameter int           N     = 8,
   parameter int           CNT_W = 16,
   parameter logic [N-1:0] PAD   = {N{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cfg_mode,
   input  logic             s_valid,
   input  logic [N-1:0]     s_data,
   output logic             s_ready,
   input  logic             flush,
   output logic             pair_valid,
   input  logic             pair_ready,
   output logic [N-1:0]     pair_in1,
   output logic [N-1:0]     pair_in2,
   output logic             pair_swap_en,
   output logic             pair_pad,
   output logic [CNT_W-1:0] pair_cnt
);

   state_e state;
   mode_e  mode_q;
   logic   accept;
   logic   swap;

   // A full pair frees its slot in the same cycle it is handed off, which is
   // what sustains one word per cycle.
   assign s_ready = (state != ST_FULL) || pair_ready;
   assign accept  = s_valid && s_ready;

   // Decision compares the held first word against the incoming second word
   // under the mode latched with the first word.
   swap_decide #(.N(N)) u_swap_decide (
      .mode (mode_q),
      .a    (pair_in1),
      .b    (s_data),
      .swap (swap)
   );

`ifdef SWAP_PAIR_FLUSH_EN
   logic pad_q;
   assign pair_pad = pad_q;
`else
   // flush and PAD exist only for interface compatibility in this build.
   logic unused_flush_pad;
   assign unused_flush_pad = ^{flush, PAD};
   assign pair_pad         = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_EMPTY;
         mode_q       <= MODE_PASS;
         pair_valid   <= 1'b0;
         pair_in1     <= '0;
         pair_in2     <= '0;
         pair_swap_en <= 1'b0;
         pair_cnt     <= '0;
`ifdef SWAP_PAIR_FLUSH_EN
         pad_q        <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (accept) begin
                  pair_in1 <= s_data;
                  mode_q   <= mode_e'(cfg_mode);
                  state    <= ST_HALF;
               end
            end
            ST_HALF: begin
               if (accept) begin
                  pair_in2     <= s_data;
                  pair_swap_en <= swap;
                  pair_valid   <= 1'b1;
`ifdef SWAP_PAIR_FLUSH_EN
                  pad_q        <= 1'b0;
`endif
                  state        <= ST_FULL;
               end
`ifdef SWAP_PAIR_FLUSH_EN
               else if (flush) begin
                  pair_in2     <= PAD;
                  pair_swap_en <= 1'b0;
                  pad_q        <= 1'b1;
                  pair_valid   <= 1'b1;
                  state        <= ST_FULL;
               end
`endif
            end
            ST_FULL: begin
               // Outputs hold until the downstream takes the pair.
               if (pair_ready) begin
                  pair_valid <= 1'b0;
                  pair_cnt   <= pair_cnt + CNT_W'(1);
                  if (accept) begin
                     pair_in1 <= s_data;
                     mode_q   <= mode_e'(cfg_mode);
                     state    <= ST_HALF;
                  end else begin
                     state    <= ST_EMPTY;
                  end
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule : swap_pair_loader

// File: tb/tb_swap_pair_loader.sv
// ---------------------------------------------------------------------------
// tb_swap_pair_loader
// Self-checking bench for swap_pair_loader (N=8, CNT_W=16): table of
// per-mode pair vectors plus directed sequences for backpressure,
// back-to-back throughput, mid-pair mode change, flush and async reset.
// ---------------------------------------------------------------------------
module tb_swap_pair_loader;

   localparam int N     = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       cfg_mode;
   logic             s_valid;
   logic [N-1:0]     s_data;
   logic             s_ready;
   logic             flush;
   logic             pair_valid;
   logic             pair_ready;
   logic [N-1:0]     pair_in1;
   logic [N-1:0]     pair_in2;
   logic             pair_swap_en;
   logic             pair_pad;
   logic [CNT_W-1:0] pair_cnt;

   swap_pair_loader #(.N(N), .CNT_W(CNT_W), .PAD(8'h00)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_mode     (cfg_mode),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .flush        (flush),
      .pair_valid   (pair_valid),
      .pair_ready   (pair_ready),
      .pair_in1     (pair_in1),
      .pair_in2     (pair_in2),
      .pair_swap_en (pair_swap_en),
      .pair_pad     (pair_pad),
      .pair_cnt     (pair_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] w1;
      logic [7:0] w2;
      logic       swap;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] w);
      s_valid = 1'b1;
      s_data  = w;
      step();
      s_valid = 1'b0;
   endtask

   task automatic check_pair(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input logic esw, input logic epad);
      check({tag, " valid"},   32'(pair_valid),   32'(1));
      check({tag, " in1"},     32'(pair_in1),     32'(e1));
      check({tag, " in2"},     32'(pair_in2),     32'(e2));
      check({tag, " swap_en"}, 32'(pair_swap_en), 32'(esw));
      check({tag, " pad"},     32'(pair_pad),     32'(epad));
   endtask

   // Hand off the pending pair with pair_ready high and no new word.
   task automatic consume(input string tag);
      pair_ready = 1'b1;
      s_valid    = 1'b0;
      step();
      exp_cnt++;
      check({tag, " valid drop"}, 32'(pair_valid), 32'(0));
      check({tag, " cnt"},        32'(pair_cnt),   32'(exp_cnt));
   endtask

   initial begin
      vecs[0] = '{2'b10, 8'hAA, 8'h55, 1'b1};
      vecs[1] = '{2'b11, 8'hAA, 8'h55, 1'b0};
      vecs[2] = '{2'b01, 8'h0F, 8'hF0, 1'b1};
      vecs[3] = '{2'b00, 8'h0F, 8'hF0, 1'b0};
      vecs[4] = '{2'b10, 8'h3C, 8'h3C, 1'b0};
      vecs[5] = '{2'b11, 8'h3C, 8'h3C, 1'b0};
      vecs[6] = '{2'b10, 8'h55, 8'hAA, 1'b0};
      vecs[7] = '{2'b11, 8'h55, 8'hAA, 1'b1};

      rst        = 1'b1;
      cfg_mode   = 2'b00;
      s_valid    = 1'b0;
      s_data     = '0;
      flush      = 1'b0;
      pair_ready = 1'b1;
      step();
      step();

      // Reset state
      check("rst valid",   32'(pair_valid),   32'(0));
      check("rst in1",     32'(pair_in1),     32'(0));
      check("rst in2",     32'(pair_in2),     32'(0));
      check("rst swap_en", 32'(pair_swap_en), 32'(0));
      check("rst pad",     32'(pair_pad),     32'(0));
      check("rst cnt",     32'(pair_cnt),     32'(0));
      check("rst s_ready", 32'(s_ready),      32'(1));
      rst = 1'b0;
      step();

      // Per-mode pair vectors
      for (int i = 0; i < 8; i++) begin
         cfg_mode = vecs[i].mode;
         send(vecs[i].w1);
         check($sformatf("vec%0d not yet valid", i), 32'(pair_valid), 32'(0));
         send(vecs[i].w2);
         check_pair($sformatf("vec%0d", i), vecs[i].w1, vecs[i].w2, vecs[i].swap, 1'b0);
         consume($sformatf("vec%0d", i));
         check($sformatf("vec%0d in1 hold", i), 32'(pair_in1), 32'(vecs[i].w1));
      end

      // Backpressure: pair (11,22) stalls, 33 waits, released together
      cfg_mode   = 2'b00;
      pair_ready = 1'b0;
      send(8'h11);
      send(8'h22);
      s_valid  = 1'b1;
      s_data   = 8'h33;
      cfg_mode = 2'b10;
      check("bp s_ready low", 32'(s_ready), 32'(0));
      step();
      step();
      check_pair("bp held", 8'h11, 8'h22, 1'b0, 1'b0);
      check("bp cnt held", 32'(pair_cnt), 32'(exp_cnt));
      check("bp s_ready still low", 32'(s_ready), 32'(0));
      pair_ready = 1'b1;
      #1;
      check("bp s_ready release", 32'(s_ready), 32'(1));
      step();
      s_valid = 1'b0;
      exp_cnt++;
      check("bp valid drop", 32'(pair_valid), 32'(0));
      check("bp cnt once",   32'(pair_cnt),   32'(exp_cnt));
      check("bp in1 33",     32'(pair_in1),   32'(8'h33));
      cfg_mode = 2'b00;
      send(8'h22);  // 33 > 22 under latched ascending mode
      check_pair("bp next", 8'h33, 8'h22, 1'b1, 1'b0);
      consume("bp next");

      // Throughput: four back-to-back words with pair_ready high
      cfg_mode = 2'b01;
      s_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_data = 8'(i);
         check($sformatf("tp s_ready %0d", i), 32'(s_ready), 32'(1));
         step();
         if (i == 2) check_pair("tp pair1", 8'h01, 8'h02, 1'b1, 1'b0);
      end
      s_valid = 1'b0;
      exp_cnt++;
      check_pair("tp pair2", 8'h03, 8'h04, 1'b1, 1'b0);
      check("tp cnt mid", 32'(pair_cnt), 32'(exp_cnt));
      consume("tp pair2");

      // Mode change mid-pair uses the mode latched with the first word
      cfg_mode = 2'b10;
      send(8'hAA);
      cfg_mode = 2'b11;
      send(8'h55);
      check_pair("latched mode", 8'hAA, 8'h55, 1'b1, 1'b0);
      consume("latched mode");

      // Flush of a lone word
      cfg_mode = 2'b01;
      send(8'h0F);
      flush = 1'b1;
      step();
      flush = 1'b0;
`ifdef SWAP_PAIR_FLUSH_EN
      check_pair("flush", 8'h0F, 8'h00, 1'b0, 1'b1);
      consume("flush");
      send(8'h0F);
`else
      check("flush ignored", 32'(pair_valid), 32'(0));
      step();
      check("flush ignored later", 32'(pair_valid), 32'(0));
      check("flush cnt", 32'(pair_cnt), 32'(exp_cnt));
`endif

      // Asynchronous reset while HALF holds 0F
      check("pre-rst in1", 32'(pair_in1), 32'(8'h0F));
      #2;
      rst = 1'b1;
      #1;
      check("async rst in1",     32'(pair_in1),     32'(0));
      check("async rst in2",     32'(pair_in2),     32'(0));
      check("async rst valid",   32'(pair_valid),   32'(0));
      check("async rst swap_en", 32'(pair_swap_en), 32'(0));
      check("async rst cnt",     32'(pair_cnt),     32'(0));
      step();
      rst     = 1'b0;
      exp_cnt = 0;
      cfg_mode = 2'b10;
      send(8'hA5);
      check("post-rst not valid", 32'(pair_valid), 32'(0));
      send(8'h5A);
      check_pair("post-rst", 8'hA5, 8'h5A, 1'b1, 1'b0);
      consume("post-rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_swap_pair_loader

// File: doc/swap_pair_loader.md
Name: swap_pair_loader

Overview:
- Upstream feeder for data_swapper.
- Collects a valid/ready stream of N-bit words into ordered pairs.
- Decides per pair whether to swap, according to a configured mode.
- Presents registered in1/in2/swap_en to the swapper behind a valid/ready handshake; the swapper's in1/in2/swap_en connect directly to pair_in1/pair_in2/pair_swap_en.

Parameters:
- N, 8, word width; must match data_swapper N.
- CNT_W, 16, width of the completed-pair counter.
- PAD, {N{1'b0}}, filler word for flushed half-pairs (used only when the optional feature is compiled in).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  00 pass, 01 always swap, 10 sort ascending, 11 sort descending.
- s_valid  in  1  input word valid.
- s_data  in  N  input word.
- s_ready  out  1  loader can accept s_data this cycle.
- flush  in  1  single-cycle request to emit a held lone word.
- pair_valid  out  1  pair outputs valid.
- pair_ready  in  1  downstream accepts the pair.
- pair_in1  out  N  first word, to data_swapper in1.
- pair_in2  out  N  second word, to data_swapper in2.
- pair_swap_en  out  1  to data_swapper swap_en.
- pair_pad  out  1  pair_in2 is PAD, not real data.
- pair_cnt  out  CNT_W  number of pairs handed off; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state EMPTY.
  - pair_valid=0, pair_in1=0, pair_in2=0, pair_swap_en=0, pair_pad=0, pair_cnt=0.
  - Held words are discarded.
  - Reset asserted mid-pair drops any partial or pending pair with no output.
- Word acceptance: a word is accepted when s_valid && s_ready. s_ready = (state != FULL) || pair_ready.
- State EMPTY:
  - On accept: store word into pair_in1, latch cfg_mode into mode_q, go to HALF.
  - flush is ignored.
- State HALF:
  - On accept: store word into pair_in2, register pair_swap_en, set pair_valid=1 and pair_pad=0, go to FULL.
  - Swap decision uses mode_q, not live cfg_mode:
    - 00 → 0.
    - 01 → 1.
    - 10 → (pair_in1 > s_data), unsigned.
    - 11 → (pair_in1 < s_data), unsigned.
    - Equal words never swap in sort modes.
- State FULL:
  - Outputs are held stable while pair_valid && !pair_ready.
  - On pair_ready: pair_valid drops and pair_cnt increments (wraps at 2^CNT_W).
  - If a word is accepted in the same cycle, it goes to pair_in1, mode_q is relatched, and the next state is HALF. Otherwise the next state is EMPTY.
- Latency: pair_valid rises the cycle after the second word is accepted.
- Throughput: sustains one word per cycle with pair_ready held high.
- cfg_mode changes mid-pair affect only the next pair.
- pair_in1/pair_in2 hold their last values after handoff; only pair_valid qualifies them.

Optional Feature:
- Macro: SWAP_PAIR_FLUSH_EN.
- Defined:
  - In HALF with flush=1 and no word accepted that cycle: pair_in2=PAD, pair_swap_en=0, pair_pad=1, pair_valid=1, go to FULL.
  - flush in the same cycle as a HALF accept is ignored; the pair completes normally with pair_pad=0.
  - flush in EMPTY or FULL is ignored.
- Not defined:
  - flush port remains but is ignored.
  - pair_pad is tied to 0.
  - PAD is unused.

Decomposition:
- Package swap_pair_pkg holds:
  - typedef enum mode_e {MODE_PASS, MODE_SWAP, MODE_ASC, MODE_DESC} (2-bit).
  - typedef enum state_e {ST_EMPTY, ST_HALF, ST_FULL} (2-bit).
- Sub-module: swap_decide, combinational; inputs mode, a, b; output swap. It is instantiated once and is reused by later sorting-network stages.

Test Plan:
- mode=10; words 8'hAA then 8'h55; pair_ready=1 → pair_in1=AA, pair_in2=55, pair_swap_en=1, pair_valid for one cycle, pair_cnt=1. The downstream swapper outputs 55, AA.
- mode=11 with AA,55 → swap_en=0. mode=01 with 0F,F0 → swap_en=1. mode=00 with 0F,F0 → swap_en=0. mode=10 with 3C,3C → swap_en=0.
- Backpressure: pair_ready=0 after pair (11,22) → outputs stable, s_ready=0 with the third word 33 stalled. Raise pair_ready → 33 is accepted the same cycle, state HALF, pair_cnt increments once.
- cfg_mode changed from 10 to 11 between word 1 (AA) and word 2 (55) → swap_en=1, using the latched mode.
- With SWAP_PAIR_FLUSH_EN: word 0F, then flush → pair_in1=0F, pair_in2=00, pair_pad=1, swap_en=0. Without the macro, the same stimulus produces no pair_valid.
- Assert rst while in HALF holding 0F → all outputs 0 immediately (asynchronous), state EMPTY. The next word A5 becomes pair_in1 of a fresh pair.
